// File: rtl/merge_table_resolver_pkg.sv
// Shared types for the merge-table resolver: default label width and the FSM
// state encoding (3 bits so a bench can probe the state directly).
package merge_table_resolver_pkg;

  localparam int DEF_WORD_SIZE = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ_I  = 3'd1,
    S_CHECK_I = 3'd2,
    S_READ_P  = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/merge_table_resolver_ram_port_mux.sv
// Selects who drives the merge-table RAM: the labeler while the resolver is
// idle, the resolver while it is busy. Purely combinational, zero latency.
module merge_table_resolver_ram_port_mux
  import merge_table_resolver_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 sel_res,
  input  logic                 lbl_wen,
  input  logic [WORD_SIZE-1:0] lbl_waddr,
  input  logic [WORD_SIZE-1:0] lbl_wdata,
  input  logic [WORD_SIZE-1:0] lbl_raddr,
  input  logic                 res_wen,
  input  logic [WORD_SIZE-1:0] res_waddr,
  input  logic [WORD_SIZE-1:0] res_wdata,
  input  logic [WORD_SIZE-1:0] res_raddr,
  output logic                 ram_wen,
  output logic [WORD_SIZE-1:0] ram_waddr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic [WORD_SIZE-1:0] ram_raddr
);

  assign ram_wen   = sel_res ? res_wen   : lbl_wen;
  assign ram_waddr = sel_res ? res_waddr : lbl_waddr;
  assign ram_wdata = sel_res ? res_wdata : lbl_wdata;
  assign ram_raddr = sel_res ? res_raddr : lbl_raddr;

endmodule

// File: rtl/merge_table_resolver.sv
// End-of-frame merge-table flattening: points every label 1..n-1 at its root
// and counts roots, owning the RAM ports while busy.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | labeler owns RAM; wait for start
// READ_I    | present entry i to the RAM
// CHECK_I   | classify entry i: root / invalid (counted as root) / child
// READ_P    | present parent p (already flattened) to the RAM
// WRITE     | write p's root back into entry i
// DONE      | one-cycle done pulse, publish object count
module merge_table_resolver
  import merge_table_resolver_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_labels,
  output logic                 busy,
  output logic                 done,
  output logic                 stall,
  output logic [WORD_SIZE-1:0] num_objects,
  output logic                 err,
  input  logic                 lbl_wen,
  input  logic [WORD_SIZE-1:0] lbl_waddr,
  input  logic [WORD_SIZE-1:0] lbl_wdata,
  input  logic [WORD_SIZE-1:0] lbl_raddr,
  output logic                 ram_wen,
  output logic [WORD_SIZE-1:0] ram_waddr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic [WORD_SIZE-1:0] ram_raddr,
  input  logic [WORD_SIZE-1:0] ram_rdata
);

  state_t               state, state_nx;
  logic [WORD_SIZE-1:0] i, n, p, count;
  logic [WORD_SIZE-1:0] n_m1;
  logic                 last, is_root;
  logic                 res_wen;
  logic [WORD_SIZE-1:0] res_waddr, res_wdata, res_raddr;

  assign n_m1    = n - 1'b1;
  assign last    = (i == n_m1);
  // An entry pointing upward is invalid; it is still treated as a root.
  assign is_root = (ram_rdata >= i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = (num_labels <= WORD_SIZE'(1)) ? S_DONE : S_READ_I;
      S_READ_I:  state_nx = S_CHECK_I;
      S_CHECK_I: begin
        if (!is_root)  state_nx = S_READ_P;
        else if (last) state_nx = S_DONE;
        else           state_nx = S_READ_I;
      end
      S_READ_P:  state_nx = S_WRITE;
      S_WRITE:   state_nx = last ? S_DONE : S_READ_I;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    res_wen   = 1'b0;
    res_waddr = i;
    res_wdata = ram_rdata;
    res_raddr = i;
    case (state)
      S_READ_P: res_raddr = p;
      S_WRITE: begin
        res_wen   = 1'b1;
        res_raddr = p;
      end
      default: ;
    endcase
  end

  assign stall = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i           <= '0;
      n           <= '0;
      p           <= '0;
      count       <= '0;
      err         <= 1'b0;
      num_objects <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n     <= num_labels;
            i     <= WORD_SIZE'(1);
            err   <= 1'b0;
            count <= '0;
          end
        end
        S_CHECK_I: begin
          p <= ram_rdata;
          if (is_root) begin
            count <= count + 1'b1;
            if (ram_rdata > i) err <= 1'b1;
            if (!last) i <= i + 1'b1;
          end
        end
        S_WRITE:  if (!last) i <= i + 1'b1;
        S_DONE:   num_objects <= count;
        default: ;
      endcase
    end
  end

  merge_table_resolver_ram_port_mux #(.WORD_SIZE(WORD_SIZE)) u_mux (
    .sel_res   (busy),
    .lbl_wen   (lbl_wen),
    .lbl_waddr (lbl_waddr),
    .lbl_wdata (lbl_wdata),
    .lbl_raddr (lbl_raddr),
    .res_wen   (res_wen),
    .res_waddr (res_waddr),
    .res_wdata (res_wdata),
    .res_raddr (res_raddr),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr)
  );

endmodule

// File: tb/tb_merge_table_resolver.sv
// Bench for merge_table_resolver: RAM model plus a table-level reference that
// flattens a copy of the table and predicts writes, run length and counts.
module tb_merge_table_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_labels;
  logic       busy, done, stall, err;
  logic [7:0] num_objects;
  logic       lbl_wen;
  logic [7:0] lbl_waddr, lbl_wdata, lbl_raddr;
  logic       ram_wen;
  logic [7:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;

  logic [7:0] mem [0:255];

  typedef struct {int a; int d;} wr_t;
  wr_t wq[$];
  int  exp_tab [0:255];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  merge_table_resolver dut (
    .clk(clk), .reset(reset), .start(start), .num_labels(num_labels),
    .busy(busy), .done(done), .stall(stall), .num_objects(num_objects), .err(err),
    .lbl_wen(lbl_wen), .lbl_waddr(lbl_waddr), .lbl_wdata(lbl_wdata), .lbl_raddr(lbl_raddr),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of port ownership and resolver writes against the model.
  task automatic monitor();
    wr_t w;
    chk("stall_eq_busy", int'(stall), int'(busy));
    if (!busy) begin
      chk("idle_wen",   int'(ram_wen),   int'(lbl_wen));
      chk("idle_waddr", int'(ram_waddr), int'(lbl_waddr));
      chk("idle_wdata", int'(ram_wdata), int'(lbl_wdata));
      chk("idle_raddr", int'(ram_raddr), int'(lbl_raddr));
    end else if (ram_wen) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", int'(ram_waddr), -1);
      end else begin
        w = wq.pop_front();
        chk("write_addr", int'(ram_waddr), w.a);
        chk("write_data", int'(ram_wdata), w.d);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int d);
    lbl_wen   = 1'b1;
    lbl_waddr = 8'(a);
    lbl_wdata = 8'(d);
    step();
    lbl_wen = 1'b0;
  endtask

  // Reference: flatten a snapshot in ascending label order.
  task automatic model_run(input int nl, output int cyc, output int obj, output int e);
    int t [0:255];
    for (int k = 0; k < 256; k++) t[k] = int'(mem[k]);
    cyc = 1; obj = 0; e = 0;
    wq.delete();
    if (nl > 1) begin
      for (int k = 1; k < nl; k++) begin
        if (t[k] >= k) begin
          obj++;
          if (t[k] > k) e = 1;
          cyc += 2;
        end else begin
          t[k] = t[t[k]];
          wq.push_back('{a: k, d: t[k]});
          cyc += 4;
        end
      end
    end
    for (int k = 0; k < 256; k++) exp_tab[k] = t[k];
  endtask

  task automatic run_case(input string nm, input int nl, input int lit_cyc,
                          input int lit_obj, input int lit_err, input int abort_at);
    int cyc, obj, e, c;
    bit seen;
    model_run(nl, cyc, obj, e);
    if (lit_cyc >= 0) begin
      chk({nm, "_model_cycles"}, cyc, lit_cyc);
      chk({nm, "_model_objects"}, obj, lit_obj);
      chk({nm, "_model_err"}, e, lit_err);
    end
    start = 1'b1;
    num_labels = 8'(nl);
    step();
    seen = 1'b0;
    c = 0;
    while (!seen && c < cyc + 8) begin
      c++;
      start      = 1'($urandom);
      num_labels = 8'($urandom);
      lbl_wen    = 1'($urandom);
      lbl_waddr  = 8'($urandom);
      lbl_wdata  = 8'($urandom);
      lbl_raddr  = 8'($urandom);
      if (c == abort_at) begin
        start = 1'b0;
        lbl_wen = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk({nm, "_abort_busy"}, int'(busy), 0);
        chk({nm, "_abort_done"}, int'(done), 0);
        chk({nm, "_abort_num_objects"}, int'(num_objects), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wq.delete();
        return;
      end
      @(negedge clk);
      monitor();
      if (done) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    lbl_wen = 1'b0;
    chk({nm, "_done_seen"}, int'(seen), 1);
    chk({nm, "_cycles"}, c, cyc);
    @(negedge clk);
    monitor();
    chk({nm, "_busy_after"}, int'(busy), 0);
    chk({nm, "_done_single"}, int'(done), 0);
    chk({nm, "_num_objects"}, int'(num_objects), obj);
    chk({nm, "_err"}, int'(err), e);
    chk({nm, "_writes_left"}, wq.size(), 0);
    for (int k = 1; k < nl; k++) chk({nm, "_table"}, int'(mem[k]), exp_tab[k]);
    if (lit_cyc >= 0) begin
      chk({nm, "_lit_cycles"}, c, lit_cyc);
      chk({nm, "_lit_objects"}, int'(num_objects), lit_obj);
      chk({nm, "_lit_err"}, int'(err), lit_err);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nl, r;
    reset = 1'b1;
    start = 1'b0;
    num_labels = '0;
    lbl_wen = 1'b0;
    lbl_waddr = '0;
    lbl_wdata = '0;
    lbl_raddr = '0;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_num_objects", int'(num_objects), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    lbl_wen = 1'b1; lbl_waddr = 8'd7; lbl_wdata = 8'd7; lbl_raddr = 8'd3;
    #1;
    chk("arb_idle_wen", int'(ram_wen), 1);
    chk("arb_idle_waddr", int'(ram_waddr), 7);
    chk("arb_idle_wdata", int'(ram_wdata), 7);
    chk("arb_idle_raddr", int'(ram_raddr), 3);
    step();
    lbl_wen = 1'b0;

    run_case("zero", 1, 1, 0, 0, -1);

    for (int k = 1; k <= 4; k++) write_entry(k, k);
    run_case("identity", 5, 9, 4, 0, -1);

    write_entry(1, 1); write_entry(2, 1); write_entry(3, 2); write_entry(4, 3);
    run_case("chain", 5, 15, 1, 0, -1);
    for (int k = 1; k <= 4; k++) chk("chain_all_one", int'(mem[k]), 1);

    write_entry(1, 1); write_entry(2, 3); write_entry(3, 1);
    run_case("invalid", 4, 9, 2, 1, -1);
    chk("invalid_entry2_kept", int'(mem[2]), 3);
    chk("invalid_entry3", int'(mem[3]), 1);

    write_entry(1, 1); write_entry(2, 1); write_entry(3, 2); write_entry(4, 3);
    run_case("abort", 5, -1, 0, 0, 8);
    chk("abort_entry3_untouched", int'(mem[3]), 2);
    step();
    run_case("resume", 5, 15, 1, 0, -1);

    for (int t = 0; t < 20; t++) begin
      nl = $urandom_range(40, 0);
      for (int k = 1; k < nl; k++) begin
        r = $urandom_range(7, 0);
        if (r == 0) write_entry(k, $urandom_range(nl - 1, 1));
        else        write_entry(k, $urandom_range(k, 1));
      end
      run_case("random", nl, -1, 0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
